alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width; power of two, minimum 4.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: bgn  input  1  start request; sampled only in IDLE.
REQ-005 Port: opcode  input  5  operation code (ADD..INC/DEC, HLT, NOP encodings of the existing opcode set).
REQ-006 Port: A, B  input  WIDTH each  operands; sampled with bgn.
REQ-007 Port: acc1  output  WIDTH  low result / quotient.
REQ-008 Port: acc2  output  WIDTH  high product / remainder; 0 for single-width ops.
REQ-009 Port: zero, negative, carry, overflow  output  1 each  registered status flags.
REQ-010 Port: rdy  output  1  one-cycle completion pulse.
REQ-011 Port: busy  output  1  high in EXEC and DONE.
REQ-012 Port: halted  output  1  sticky, set by HLT, cleared only by reset.

Function
REQ-013 FSM states IDLE, EXEC, DONE; IDLE->EXEC on edge with bgn=1 and halted=0; EXEC->DONE when op complete; DONE->IDLE unconditionally.
REQ-014 On IDLE->EXEC edge A, B, opcode SHALL be latched; later input changes have no effect on the running op.
REQ-015 bgn in EXEC/DONE SHALL be ignored (not queued); bgn held high restarts on the first IDLE edge.
REQ-016 Single-cycle ops (ADD SUB LSR LSL RSR RSL AND OR XOR NOT CMP TST INC DEC NOP HLT): one EXEC cycle; rdy high in the cycle after the 2nd edge following the bgn-sampling edge.
REQ-017 MUL: unsigned shift-add, exactly WIDTH EXEC cycles, iteration counter; {acc2,acc1} = A*B, full 2*WIDTH product.
REQ-018 DIV/MOD: unsigned restoring, exactly WIDTH EXEC cycles; both write acc1=quotient, acc2=remainder.
REQ-019 DIV/MOD with B=0: one EXEC cycle; acc1=all ones, acc2=A, overflow=1.
REQ-020 ADD/SUB/INC/DEC: modulo 2^WIDTH; carry=carry-out (ADD/INC) or borrow (SUB/DEC, i.e. A<B unsigned); overflow=two's-complement signed overflow.
REQ-021 LSL/LSR: logical shift of A by B; B>=WIDTH yields 0; carry=last bit shifted out (0 if B=0).
REQ-022 RSL/RSR: rotate A by B mod WIDTH.
REQ-023 CMP computes A-B, TST computes A&B: flags updated, acc1/acc2 unchanged.
REQ-024 NOP and undefined opcodes: rdy pulse, acc1/acc2/flags unchanged.
REQ-025 HLT: rdy pulse, sets halted; subsequent bgn ignored until reset.
REQ-026 Result-writing ops: zero=({acc2,acc1}==0); negative=MSB of acc2 for MUL else MSB of acc1; carry/overflow 0 unless defined above.
REQ-027 acc1, acc2, flags SHALL be registered and stable from the rdy edge until the next result write.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, counter 0, acc1=acc2=0, all flags 0, rdy=0, busy=0, halted=0.
REQ-029 Reset mid-EXEC SHALL abort the op with no partial result visible; first bgn after release starts normally.

Structure
REQ-030 Opcode constants and FSM state encoding SHALL live in shared package alu_pkg, also used by the decoder.
REQ-031 Iterative MUL/DIV datapath SHALL be sub-module alu_iter_unit (start, done, WIDTH parameter); single-cycle ops stay in alu_multicycle.

Verification (WIDTH=16)
REQ-032 ADD A=0xFFFF B=0x0001 -> acc1=0x0000, zero=1, carry=1, overflow=0, rdy 2 cycles after bgn edge.
REQ-033 SUB A=0x8000 B=0x0001 -> acc1=0x7FFF, overflow=1, carry=0, negative=0.
REQ-034 MUL A=0x1234 B=0x0100 -> acc2=0x0012, acc1=0x3400, rdy 17 edges after bgn edge; bgn pulses during EXEC ignored.
REQ-035 DIV A=100 B=7 -> acc1=14, acc2=2; DIV A=5 B=0 -> acc1=0xFFFF, acc2=5, overflow=1, one EXEC cycle.
REQ-036 rst_n low at 5th EXEC cycle of MUL -> all outputs 0 asynchronously, no rdy; next ADD 2+3 -> acc1=5.
REQ-037 HLT -> rdy pulse, halted=1; following bgn with ADD -> no rdy, busy stays 0 until reset.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode set, FSM encoding and decode helpers for alu_multicycle
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD = 5'd0,
    OP_SUB = 5'd1,
    OP_LSR = 5'd2,
    OP_LSL = 5'd3,
    OP_RSR = 5'd4,
    OP_RSL = 5'd5,
    OP_AND = 5'd6,
    OP_OR  = 5'd7,
    OP_XOR = 5'd8,
    OP_NOT = 5'd9,
    OP_CMP = 5'd10,
    OP_TST = 5'd11,
    OP_INC = 5'd12,
    OP_DEC = 5'd13,
    OP_MUL = 5'd14,
    OP_DIV = 5'd15,
    OP_MOD = 5'd16,
    OP_NOP = 5'd17,
    OP_HLT = 5'd18
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } flags_t;

  function automatic logic is_divide(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

  // Divide by zero short-circuits to a single EXEC cycle instead of iterating.
  function automatic logic is_iter_op(input logic [4:0] op, input logic b_zero);
    return (op == OP_MUL) || (is_divide(op) && !b_zero);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// rtl/alu_iter_unit.sv - WIDTH-step shift-add multiplier / restoring divider
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] res_lo_o
);

  localparam int CW = $clog2(WIDTH);

  logic             run_q;
  logic             div_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_tr;

  // hi/lo hold partial product / multiplier for MUL, remainder / quotient for DIV.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_sh  = {hi_q, lo_q[WIDTH-1]};
    div_tr  = div_sh - {1'b0, b_q};
    if (div_q) begin
      if (div_tr[WIDTH]) begin
        hi_d = div_sh[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
        hi_d = div_tr[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      hi_d = mul_sum[WIDTH:1];
      lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign done     = run_q && (cnt_q == CW'(WIDTH - 1));
  assign res_hi_o = hi_d;
  assign res_lo_o = lo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      div_q <= 1'b0;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      div_q <= is_div_i;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= a_i;
      b_q   <= b_i;
    end else if (run_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + CW'(1);
      if (done) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multicycle ALU with IDLE/EXEC/DONE control and registered results
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bgn,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] acc1,
  output logic [WIDTH-1:0] acc2,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             rdy,
  output logic             busy,
  output logic             halted
);

  localparam int SW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] acc1_q, acc2_q;
  flags_t           flags_q;
  logic             rdy_q, halted_q;

  logic             start, iter_start, iter_op, iter_done, exec_done;
  logic [WIDTH-1:0] iter_hi, iter_lo;

  logic [WIDTH-1:0]   opnd_b, res;
  logic [WIDTH:0]     sum_ext, sh_ext;
  logic [2*WIDTH-1:0] rot;
  logic               res_c, res_v, wr_acc, wr_flg, do_halt;

  assign start      = (state_q == ST_IDLE) && bgn && !halted_q;
  assign iter_start = start && is_iter_op(opcode, B == '0);
  assign iter_op    = is_iter_op(op_q, b_q == '0);
  assign exec_done  = (state_q == ST_EXEC) && (!iter_op || iter_done);

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (iter_start),
    .is_div_i (is_divide(opcode)),
    .a_i      (A),
    .b_i      (B),
    .done     (iter_done),
    .res_hi_o (iter_hi),
    .res_lo_o (iter_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_EXEC;
      ST_EXEC: if (exec_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  // Single-cycle datapath, evaluated from the operands latched at start.
  always_comb begin
    res     = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    wr_acc  = 1'b0;
    wr_flg  = 1'b0;
    do_halt = 1'b0;
    sum_ext = '0;
    sh_ext  = '0;
    rot     = '0;
    opnd_b  = (op_q == OP_INC || op_q == OP_DEC) ? WIDTH'(1) : b_q;
    case (op_q)
      OP_ADD, OP_INC: begin
        sum_ext = {1'b0, a_q} + {1'b0, opnd_b};
        res     = sum_ext[WIDTH-1:0];
        res_c   = sum_ext[WIDTH];
        res_v   = (a_q[WIDTH-1] == opnd_b[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
        wr_acc  = 1'b1;
        wr_flg  = 1'b1;
      end
      OP_SUB, OP_DEC, OP_CMP: begin
        sum_ext = {1'b0, a_q} - {1'b0, opnd_b};
        res     = sum_ext[WIDTH-1:0];
        res_c   = sum_ext[WIDTH];
        res_v   = (a_q[WIDTH-1] != opnd_b[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
        wr_acc  = (op_q != OP_CMP);
        wr_flg  = 1'b1;
      end
      OP_LSL: begin
        sh_ext = {1'b0, a_q} << b_q;
        res    = sh_ext[WIDTH-1:0];
        res_c  = sh_ext[WIDTH];
        wr_acc = 1'b1;
        wr_flg = 1'b1;
      end
      OP_LSR: begin
        sh_ext = {a_q, 1'b0} >> b_q;
        res    = sh_ext[WIDTH:1];
        res_c  = sh_ext[0];
        wr_acc = 1'b1;
        wr_flg = 1'b1;
      end
      OP_RSL: begin
        rot    = {a_q, a_q} << b_q[SW-1:0];
        res    = rot[2*WIDTH-1:WIDTH];
        wr_acc = 1'b1;
        wr_flg = 1'b1;
      end
      OP_RSR: begin
        rot    = {a_q, a_q} >> b_q[SW-1:0];
        res    = rot[WIDTH-1:0];
        wr_acc = 1'b1;
        wr_flg = 1'b1;
      end
      OP_AND: begin res = a_q & b_q; wr_acc = 1'b1; wr_flg = 1'b1; end
      OP_OR:  begin res = a_q | b_q; wr_acc = 1'b1; wr_flg = 1'b1; end
      OP_XOR: begin res = a_q ^ b_q; wr_acc = 1'b1; wr_flg = 1'b1; end
      OP_NOT: begin res = ~a_q;      wr_acc = 1'b1; wr_flg = 1'b1; end
      OP_TST: begin res = a_q & b_q; wr_flg = 1'b1; end
      OP_HLT: do_halt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc1_q   <= '0;
      acc2_q   <= '0;
      flags_q  <= '0;
      rdy_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      rdy_q <= (state_q == ST_DONE);
      if (start) begin
        op_q <= opcode;
        a_q  <= A;
        b_q  <= B;
      end
      if (exec_done) begin
        if (iter_op) begin
          acc1_q  <= iter_lo;
          acc2_q  <= iter_hi;
          flags_q <= {({iter_hi, iter_lo} == '0),
                      (op_q == OP_MUL) ? iter_hi[WIDTH-1] : iter_lo[WIDTH-1],
                      1'b0, 1'b0};
        end else if (is_divide(op_q)) begin
          acc1_q  <= '1;
          acc2_q  <= a_q;
          flags_q <= 4'b0101;
        end else begin
          if (wr_acc) begin
            acc1_q <= res;
            acc2_q <= '0;
          end
          if (wr_flg) begin
            flags_q <= {(res == '0), res[WIDTH-1], res_c, res_v};
          end
          if (do_halt) begin
            halted_q <= 1'b1;
          end
        end
      end
    end
  end

  assign acc1     = acc1_q;
  assign acc2     = acc2_q;
  assign zero     = flags_q.zero;
  assign negative = flags_q.negative;
  assign carry    = flags_q.carry;
  assign overflow = flags_q.overflow;
  assign rdy      = rdy_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - directed self-checking bench for alu_multicycle
module tb_alu_multicycle;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bgn = 1'b0;
  logic [4:0]  opcode = '0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [15:0] acc1, acc2;
  logic        zero, negative, carry, overflow, rdy, busy, halted;
  logic [3:0]  flg;

  int checks = 0;
  int errors = 0;
  int n, cnt;

  assign flg = {zero, negative, carry, overflow};

  alu_multicycle #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bgn      (bgn),
    .opcode   (opcode),
    .A        (A),
    .B        (B),
    .acc1     (acc1),
    .acc2     (acc2),
    .zero     (zero),
    .negative (negative),
    .carry    (carry),
    .overflow (overflow),
    .rdy      (rdy),
    .busy     (busy),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    opcode = op;
    A      = a;
    B      = b;
    bgn    = 1'b1;
    tick();
    bgn    = 1'b0;
  endtask

  task automatic wait_rdy(output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (rdy !== 1'b1 && edges < 100);
  endtask

  task automatic run_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                        output int edges);
    start_op(op, a, b);
    wait_rdy(edges);
  endtask

  initial begin
    #2;
    chk("rst_acc1", acc1, 16'h0000);
    chk("rst_acc2", acc2, 16'h0000);
    chk("rst_flags", flg, 4'b0000);
    chk("rst_ctl", {rdy, busy, halted}, 3'b000);
    #10 rst_n = 1'b1;
    tick();

    start_op(OP_ADD, 16'hFFFF, 16'h0001);
    chk("add_busy", busy, 1'b1);
    wait_rdy(n);
    chk("add_lat", n, 2);
    chk("add_acc1", acc1, 16'h0000);
    chk("add_acc2", acc2, 16'h0000);
    chk("add_flags", flg, 4'b1010);
    tick();
    chk("add_rdy_pulse", rdy, 1'b0);

    run_op(OP_SUB, 16'h8000, 16'h0001, n);
    chk("sub_acc1", acc1, 16'h7FFF);
    chk("sub_flags", flg, 4'b0001);

    start_op(OP_MUL, 16'h1234, 16'h0100);
    opcode = OP_ADD; A = 16'h0000; B = 16'h0000; bgn = 1'b1;
    repeat (3) tick();
    bgn = 1'b0;
    wait_rdy(n);
    chk("mul_lat", n + 3, 17);
    chk("mul_acc2", acc2, 16'h0012);
    chk("mul_acc1", acc1, 16'h3400);
    chk("mul_flags", flg, 4'b0000);
    tick();
    chk("mul_no_queue", {busy, rdy}, 2'b00);

    run_op(OP_MUL, 16'hFFFF, 16'hFFFF, n);
    chk("mulmax_prod", {acc2, acc1}, 32'hFFFE0001);
    chk("mulmax_flags", flg, 4'b0100);

    run_op(OP_DIV, 16'd100, 16'd7, n);
    chk("div_lat", n, 17);
    chk("div_q", acc1, 16'd14);
    chk("div_r", acc2, 16'd2);
    chk("div_flags", flg, 4'b0000);

    run_op(OP_DIV, 16'd5, 16'd0, n);
    chk("div0_lat", n, 2);
    chk("div0_acc1", acc1, 16'hFFFF);
    chk("div0_acc2", acc2, 16'd5);
    chk("div0_flags", flg, 4'b0101);

    run_op(OP_MOD, 16'hFFFF, 16'h0010, n);
    chk("mod_res", {acc2, acc1}, 32'h000F0FFF);

    run_op(OP_LSL, 16'h8001, 16'd1, n);
    chk("lsl1", {acc1, 12'h000, flg}, {16'h0002, 12'h000, 4'b0010});
    run_op(OP_LSL, 16'h0001, 16'd16, n);
    chk("lsl16", {acc1, 12'h000, flg}, {16'h0000, 12'h000, 4'b1010});
    run_op(OP_LSR, 16'h00F0, 16'd4, n);
    chk("lsr4", {acc1, 12'h000, flg}, {16'h000F, 12'h000, 4'b0000});
    run_op(OP_LSR, 16'h00F0, 16'd20, n);
    chk("lsr20", {acc1, 12'h000, flg}, {16'h0000, 12'h000, 4'b1000});
    run_op(OP_RSL, 16'h8001, 16'd4, n);
    chk("rsl4", acc1, 16'h0018);
    run_op(OP_RSR, 16'h8001, 16'd20, n);
    chk("rsr20", acc1, 16'h1800);

    run_op(OP_CMP, 16'd3, 16'd5, n);
    chk("cmp_acc", {acc2, acc1}, 32'h00001800);
    chk("cmp_flags", flg, 4'b0110);
    run_op(OP_TST, 16'h00F0, 16'h0F00, n);
    chk("tst_acc", acc1, 16'h1800);
    chk("tst_flags", flg, 4'b1000);
    run_op(OP_NOP, 16'h1111, 16'h2222, n);
    chk("nop_lat", n, 2);
    chk("nop_keep", {acc1, 12'h000, flg}, {16'h1800, 12'h000, 4'b1000});
    run_op(5'd31, 16'h1111, 16'h2222, n);
    chk("undef_keep", {acc1, 12'h000, flg}, {16'h1800, 12'h000, 4'b1000});

    run_op(OP_ADD, 16'h7FFF, 16'h0001, n);
    chk("addv", {acc1, 12'h000, flg}, {16'h8000, 12'h000, 4'b0101});
    run_op(OP_INC, 16'hFFFF, 16'h1234, n);
    chk("inc", {acc1, 12'h000, flg}, {16'h0000, 12'h000, 4'b1010});
    run_op(OP_DEC, 16'h0000, 16'h1234, n);
    chk("dec", {acc1, 12'h000, flg}, {16'hFFFF, 12'h000, 4'b0110});

    start_op(OP_MUL, 16'h1234, 16'h0100);
    repeat (4) tick();
    chk("abort_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_acc", {acc2, acc1}, 32'h00000000);
    chk("abort_ctl", {flg, rdy, busy, halted}, 7'b0000000);
    tick();
    rst_n = 1'b1;
    cnt = 0;
    repeat (25) begin
      tick();
      if (rdy) cnt++;
    end
    chk("abort_no_rdy", cnt, 0);
    run_op(OP_ADD, 16'd2, 16'd3, n);
    chk("post_abort_lat", n, 2);
    chk("post_abort_add", acc1, 16'd5);

    run_op(OP_HLT, 16'h0000, 16'h0000, n);
    chk("hlt_lat", n, 2);
    chk("hlt_halted", halted, 1'b1);
    start_op(OP_ADD, 16'd1, 16'd1);
    chk("halt_busy", busy, 1'b0);
    cnt = 0;
    repeat (5) begin
      tick();
      if (rdy || busy) cnt++;
    end
    chk("halt_ignore", cnt, 0);
    chk("halt_acc1", acc1, 16'd5);
    rst_n = 1'b0;
    tick();
    chk("halt_cleared", halted, 1'b0);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
